avalon_burst_ram_slave: RTL and testbench

Avalon-MM burst responder backed by an on-chip byte-enabled RAM; the slave end of the 32-bit, 16-beat line-burst interface driven by the CPU bus master. It accepts single-word and 16-word line bursts, applies byte enables on writes, streams read bursts back with `readdatavalid`, and can insert programmable read wait states to stress the master's stall handling. It sits behind the FPGA interconnect as the main-memory model for simulation and as boot/scratch RAM on the board.

---
 rtl/avalon_pkg.sv | 30 +++
 rtl/avalon_bram_be.sv | 32 +++
 rtl/avalon_burst_ram_slave.sv | 122 ++++++++++++
 tb/tb_avalon_burst_ram_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared Avalon-MM burst definitions used by the CPU bus master and the RAM slave.
package avalon_pkg;

  localparam int AV_DATA_W    = 32;
  localparam int AV_ADDR_W    = 30;
  localparam int AV_BURST_W   = 5;
  localparam int AV_BURST_MAX = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } state_e;

  // Zero-length bursts become single beats; oversize bursts are cut to a full line.
  function automatic logic [AV_BURST_W-1:0] burst_clamp(input logic [AV_BURST_W-1:0] bc);
    if (bc == '0)
      return AV_BURST_W'(1);
    else if (bc > AV_BURST_W'(AV_BURST_MAX))
      return AV_BURST_W'(AV_BURST_MAX);
    else
      return bc;
  endfunction

  function automatic logic burst_bad(input logic [AV_BURST_W-1:0] bc);
    return (bc == '0) || (bc > AV_BURST_W'(AV_BURST_MAX));
  endfunction

endpackage

// File: rtl/avalon_bram_be.sv
// Single-port synchronous RAM, 32-bit words with four byte-lane write enables
// and a one-cycle registered read port that holds its value between reads.
module avalon_bram_be #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata <= '0;
    else if (rd_en)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/avalon_burst_ram_slave.sv
// Avalon-MM burst responder: single/line bursts into a byte-enabled RAM,
// with optional read wait states ahead of the read data stream.
module avalon_burst_ram_slave
  import avalon_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter int    READ_WAIT = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AV_ADDR_W-1:0]  s_address,
  input  logic [AV_BURST_W-1:0] s_burstcount,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [AV_DATA_W-1:0]  s_writedata,
  input  logic [3:0]            s_byteenable,
  output logic                  s_waitrequest,
  output logic [AV_DATA_W-1:0]  s_readdata,
  output logic                  s_readdatavalid,
  output logic                  err,
  output state_e                state_dbg
);

  localparam logic [3:0] WAIT_LOAD = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;

  // Handshake: a beat transfers on a rising clk edge where (s_read | s_write) is
  // high and s_waitrequest is low; read beats come back later, one per cycle that
  // s_readdatavalid is high, and are never back-pressured.

  state_e                state;
  logic [ADDR_W-1:0]     cur_addr;
  logic [AV_BURST_W-1:0] remain;
  logic [3:0]            wait_cnt;
  logic                  rvalid;

  logic [AV_BURST_W-1:0] bc_eff;
  logic                  bc_bad;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  wr_acc;
  logic                  rd_issue;
  logic [ADDR_W-1:0]     ram_addr;
  logic [3:0]            ram_we;
  logic                  unused_addr;

  assign bc_eff      = burst_clamp(s_burstcount);
  assign bc_bad      = burst_bad(s_burstcount);
  assign cmd_addr    = s_address[ADDR_W-1:0];
  assign unused_addr = ^s_address[AV_ADDR_W-1:ADDR_W];

  assign wr_acc   = rst_n && s_write && (state == IDLE || state == WR_BURST);
  assign rd_issue = rst_n && (state == RD_BURST);
  assign ram_addr = (state == IDLE) ? cmd_addr : cur_addr;
  assign ram_we   = wr_acc ? s_byteenable : 4'b0000;

  assign s_waitrequest   = !rst_n || (state == RD_WAIT) || (state == RD_BURST);
  assign s_readdatavalid = rvalid;
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
      wait_cnt <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= (state == RD_BURST);
      case (state)
        IDLE: begin
          if (s_write) begin
            cur_addr <= cmd_addr + ADDR_W'(1);
            remain   <= bc_eff - AV_BURST_W'(1);
            if (bc_bad || s_read) err <= 1'b1;
            if (bc_eff > AV_BURST_W'(1)) state <= WR_BURST;
          end else if (s_read) begin
            cur_addr <= cmd_addr;
            remain   <= bc_eff;
            wait_cnt <= WAIT_LOAD;
            if (bc_bad) err <= 1'b1;
            state <= (READ_WAIT > 0) ? RD_WAIT : RD_BURST;
          end
        end
        WR_BURST: begin
          if (s_read) err <= 1'b1;
          if (s_write) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            remain   <= remain - AV_BURST_W'(1);
            if (remain == AV_BURST_W'(1)) state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 4'd0)
            state <= RD_BURST;
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        RD_BURST: begin
          cur_addr <= cur_addr + ADDR_W'(1);
          remain   <= remain - AV_BURST_W'(1);
          if (remain == AV_BURST_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  avalon_bram_be #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (s_writedata),
    .rd_en (rd_issue),
    .rdata (s_readdata)
  );

endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// Directed bench: two slaves (READ_WAIT 0 and 3) share one command stream; each
// one's read beats are captured with their cycle number and checked against hand values.
module tb_avalon_burst_ram_slave;
  import avalon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] s_address = '0;
  logic [4:0]  s_burstcount = 5'd1;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [3:0]  s_byteenable = '0;

  logic        wr0, rv0, err0, wr3, rv3, err3;
  logic [31:0] rd0, rd3;
  state_e      st0, st3;

  always #5 clk = ~clk;

  avalon_burst_ram_slave #(.ADDR_W(10), .READ_WAIT(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst_n(rst_n), .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(wr0), .s_readdata(rd0),
    .s_readdatavalid(rv0), .err(err0), .state_dbg(st0)
  );

  avalon_burst_ram_slave #(.ADDR_W(10), .READ_WAIT(3), .INIT_FILE("")) dut3 (
    .clk(clk), .rst_n(rst_n), .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(wr3), .s_readdata(rd3),
    .s_readdatavalid(rv3), .err(err3), .state_dbg(st3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] got0_d[$];
  int          got0_c[$];
  logic [31:0] got3_d[$];
  int          got3_c[$];
  int          wcnt0 = 0;
  int          wcnt3 = 0;

  always @(negedge clk) begin
    if (rv0) begin
      got0_d.push_back(rd0);
      got0_c.push_back(cyc);
    end
    if (rv3) begin
      got3_d.push_back(rd3);
      got3_c.push_back(cyc);
    end
    if (rst_n && wr0) wcnt0++;
    if (rst_n && wr3) wcnt3++;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          rp0 = 0;
  int          rp3 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((wr0 || wr3) && t < 100) begin
      step();
      t++;
    end
    chk({tag, "_idle_timeout"}, 32'(t < 100), 32'd1);
    repeat (2) step();
  endtask

  task automatic write_burst(input logic [29:0] addr, input int n, input logic [4:0] bc,
                             input logic [31:0] base, input logic [3:0] be, input int bubble_at);
    for (int k = 0; k < n; k++) begin
      s_address    = addr;
      s_burstcount = bc;
      s_write      = 1'b1;
      s_writedata  = base + 32'(k);
      s_byteenable = be;
      step();
      if (k == bubble_at) begin
        s_write = 1'b0;
        step();
      end
    end
    s_write = 1'b0;
  endtask

  task automatic read_issue(input logic [29:0] addr, input logic [4:0] bc, output int n_cmd);
    n_cmd        = cyc;
    s_address    = addr;
    s_burstcount = bc;
    s_read       = 1'b1;
    step();
    s_read = 1'b0;
  endtask

  task automatic read_cmd(input string tag, input logic [29:0] addr, input logic [4:0] bc,
                          output int n_cmd);
    read_issue(addr, bc, n_cmd);
    wait_idle(tag);
  endtask

  // Beat i is due in cycle n_cmd+2+i on the zero-wait slave and n_cmd+5+i with three waits.
  task automatic check_beats(input string tag, input int n_cmd, input int n0, input int n3);
    chk({tag, "_count0"}, 32'(got0_d.size() - rp0), 32'(n0));
    for (int i = 0; i < n0; i++) begin
      if (rp0 + i < got0_d.size()) begin
        chk({tag, "_data0"}, got0_d[rp0+i], exp_q[i]);
        chk({tag, "_cyc0"}, 32'(got0_c[rp0+i]), 32'(n_cmd + 2 + i));
      end
    end
    chk({tag, "_count3"}, 32'(got3_d.size() - rp3), 32'(n3));
    for (int i = 0; i < n3; i++) begin
      if (rp3 + i < got3_d.size()) begin
        chk({tag, "_data3"}, got3_d[rp3+i], exp_q[i]);
        chk({tag, "_cyc3"}, 32'(got3_c[rp3+i]), 32'(n_cmd + 5 + i));
      end
    end
    rp0 = got0_d.size();
    rp3 = got3_d.size();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int w0;
    int w3;

    repeat (3) step();
    @(negedge clk);
    chk("rst_valid0", 32'(rv0), 32'd0);
    chk("rst_data0", rd0, 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_wait0", 32'(wr0), 32'd1);
    chk("rst_state0", 32'(st0), 32'(IDLE));
    chk("rst_valid3", 32'(rv3), 32'd0);
    chk("rst_data3", rd3, 32'd0);
    chk("rst_wait3", 32'(wr3), 32'd1);
    rst_n = 1'b1;
    step();
    chk("idle_wait0", 32'(wr0), 32'd0);

    write_burst(30'h10, 1, 5'd1, 32'hDEADBEEF, 4'hF, -1);
    read_cmd("single", 30'h10, 5'd1, n);
    exp_q.push_back(32'hDEADBEEF);
    check_beats("single", n, 1, 1);
    chk("single_err0", 32'(err0), 32'd0);
    chk("single_err3", 32'(err3), 32'd0);

    write_burst(30'h20, 16, 5'd16, 32'h100, 4'hF, 3);
    chk("line_wr_state0", 32'(st0), 32'(IDLE));
    w0 = wcnt0;
    w3 = wcnt3;
    read_cmd("line", 30'h20, 5'd16, n);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h100 + 32'(k));
    check_beats("line", n, 16, 16);
    chk("line_wait0", 32'(wcnt0 - w0), 32'd16);
    chk("line_wait3", 32'(wcnt3 - w3), 32'd19);

    write_burst(30'h5, 1, 5'd1, 32'hAABBCCDD, 4'hF, -1);
    write_burst(30'h5, 1, 5'd1, 32'h11223344, 4'h5, -1);
    read_cmd("byteen", 30'h5, 5'd1, n);
    exp_q.push_back(32'hAA22CC44);
    check_beats("byteen", n, 1, 1);

    write_burst(30'h3FE, 4, 5'd4, 32'hA0, 4'hF, -1);
    read_cmd("wrap", 30'h3FFF_FFFE, 5'd4, n);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0 + 32'(k));
    check_beats("wrap", n, 4, 4);
    read_cmd("wrap_low", 30'h0, 5'd2, n);
    exp_q.push_back(32'hA2);
    exp_q.push_back(32'hA3);
    check_beats("wrap_low", n, 2, 2);
    chk("wrap_err0", 32'(err0), 32'd0);

    write_burst(30'h40, 1, 5'd0, 32'h55, 4'hF, -1);
    chk("bc0_state0", 32'(st0), 32'(IDLE));
    chk("bc0_err0", 32'(err0), 32'd1);
    chk("bc0_err3", 32'(err3), 32'd1);
    read_cmd("bc0_rd", 30'h40, 5'd1, n);
    exp_q.push_back(32'h55);
    check_beats("bc0_rd", n, 1, 1);

    do_reset();
    chk("err_cleared0", 32'(err0), 32'd0);
    read_cmd("clamp", 30'h20, 5'd20, n);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h100 + 32'(k));
    check_beats("clamp", n, 16, 16);
    chk("clamp_err0", 32'(err0), 32'd1);

    do_reset();
    s_address    = 30'h50;
    s_burstcount = 5'd1;
    s_writedata  = 32'h77;
    s_byteenable = 4'hF;
    s_read       = 1'b1;
    s_write      = 1'b1;
    step();
    s_read  = 1'b0;
    s_write = 1'b0;
    repeat (6) step();
    chk("rw_nobeats0", 32'(got0_d.size() - rp0), 32'd0);
    chk("rw_nobeats3", 32'(got3_d.size() - rp3), 32'd0);
    chk("rw_state0", 32'(st0), 32'(IDLE));
    chk("rw_err0", 32'(err0), 32'd1);
    repeat (10) step();
    chk("rw_err_sticky0", 32'(err0), 32'd1);
    chk("rw_err_sticky3", 32'(err3), 32'd1);
    read_cmd("rw_rd", 30'h50, 5'd1, n);
    exp_q.push_back(32'h77);
    check_beats("rw_rd", n, 1, 1);

    read_issue(30'h20, 5'd16, n);
    repeat (5) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_beat5_valid0", 32'(rv0), 32'd1);
    chk("mid_rst_wait0", 32'(wr0), 32'd1);
    step();
    @(negedge clk);
    chk("mid_drop_valid0", 32'(rv0), 32'd0);
    chk("mid_drop_valid3", 32'(rv3), 32'd0);
    chk("mid_rst_wait3", 32'(wr3), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_state0", 32'(st0), 32'(IDLE));
    chk("mid_state3", 32'(st3), 32'(IDLE));
    for (int k = 0; k < 5; k++) exp_q.push_back(32'h100 + 32'(k));
    check_beats("mid", n, 5, 2);
    read_cmd("keep_a", 30'h20, 5'd1, n);
    exp_q.push_back(32'h100);
    check_beats("keep_a", n, 1, 1);
    read_cmd("keep_b", 30'h5, 5'd1, n);
    exp_q.push_back(32'hAA22CC44);
    check_beats("keep_b", n, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
